// File: rtl/systolic_skew_stream_pkg.sv
// Shared types and the per-lane delay rule for the systolic skewer/deskewer.
package systolic_pkg;

  typedef enum logic {SKEW = 1'b0, DESKEW = 1'b1} skew_mode_e;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} skew_state_e;

  // SKEW delays lane i by i steps; DESKEW mirrors that so skewed outputs realign.
  function automatic int lane_delay(skew_mode_e mode, int lanes, int i);
    return (mode == DESKEW) ? (lanes - 1 - i) : i;
  endfunction

endpackage

// File: rtl/systolic_skew_stream_lane.sv
// One skew lane: DEPTH delay registers plus an output register, all advancing on step.
module skew_lane
  import systolic_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              step,
  input  logic [DATA_W-1:0] din,
  input  logic              tin,
  output logic [DATA_W-1:0] dout,
  output logic              tout
);

  // Index DEPTH is the output register; DEPTH = 0 leaves only that register.
  logic [DATA_W-1:0] r_data [DEPTH+1];
  logic [DEPTH:0]    r_tag;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= DEPTH; k++) r_data[k] <= '0;
      r_tag <= '0;
    end else if (flush) begin
      for (int k = 0; k <= DEPTH; k++) r_data[k] <= '0;
      r_tag <= '0;
    end else if (step) begin
      r_data[0] <= din;
      r_tag[0]  <= tin;
      for (int k = 1; k <= DEPTH; k++) begin
        r_data[k] <= r_data[k-1];
        r_tag[k]  <= r_tag[k-1];
      end
    end
  end

  assign dout = r_data[DEPTH];
  assign tout = r_tag[DEPTH];

endmodule

// File: rtl/systolic_skew_stream.sv
// Flow-controlled skewer/deskewer: per-lane delay lines, a frame-last line and a
// stream/drain FSM that keeps consecutive frames from overlapping in the array.
module systolic_skew_stream
  import systolic_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = 32,
  parameter int MODE   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data [LANES-1:0],
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data [LANES-1:0],
  output logic [LANES-1:0]  out_lane_valid,
  output logic              out_last,
  output logic              busy
);

  localparam skew_mode_e MODE_E = (MODE == 1) ? DESKEW : SKEW;
  localparam int         D_MAX  = LANES - 1;

  skew_state_e      r_state;
  skew_state_e      w_next;
  logic             w_step;
  logic             w_accept;
  logic             w_lastIn;
  logic [LANES-1:0] w_tags;
  logic             w_lastData;
  logic             w_lastTag;

  // The whole array moves as one: it stalls only when a live beat is refused.
  assign w_step   = out_ready || !out_valid;
  assign in_ready = w_step && (r_state != DRAIN);
  assign w_accept = in_valid && in_ready;
  assign w_lastIn = w_accept && in_last;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    localparam int D = lane_delay(MODE_E, LANES, g);
    skew_lane #(.DATA_W(DATA_W), .DEPTH(D)) u_lane (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .step  (w_step),
      .din   (w_accept ? in_data[g] : '0),
      .tin   (w_accept),
      .dout  (out_data[g]),
      .tout  (w_tags[g])
    );
  end

  // The last line matches the longest lane, so it lands with lane L*'s element.
  skew_lane #(.DATA_W(1), .DEPTH(D_MAX)) u_last (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .step  (w_step),
    .din   (w_lastIn),
    .tin   (w_lastIn),
    .dout  (w_lastData),
    .tout  (w_lastTag)
  );

  assign out_lane_valid = w_tags;
  assign out_valid      = |w_tags;
  assign out_last       = w_lastData & w_lastTag;
  assign busy           = (r_state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_next = in_last ? DRAIN : STREAM;
        STREAM:  if (w_lastIn) w_next = DRAIN;
        DRAIN:   if (out_valid && out_ready && out_last) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_skew_stream.sv
// Directed bench: SKEW/DESKEW with 4 lanes and a 1-lane instance, checked with immediate assertions.
module tb_systolic_skew_stream;

  logic clk;
  logic reset;

  logic        aFlush, aInValid, aInReady, aInLast, aOutValid, aOutReady, aOutLast, aBusy;
  logic [31:0] aInData [3:0];
  logic [31:0] aOutData [3:0];
  logic [3:0]  aLaneValid;

  logic        bFlush, bInValid, bInReady, bInLast, bOutValid, bOutReady, bOutLast, bBusy;
  logic [31:0] bInData [3:0];
  logic [31:0] bOutData [3:0];
  logic [3:0]  bLaneValid;

  logic        cFlush, cInValid, cInReady, cInLast, cOutValid, cOutReady, cOutLast, cBusy;
  logic [31:0] cInData [0:0];
  logic [31:0] cOutData [0:0];
  logic [0:0]  cLaneValid;

  int checks;
  int failures;

  systolic_skew_stream #(.LANES(4), .DATA_W(32), .MODE(0)) dutA (
    .clk(clk), .reset(reset), .flush(aFlush), .in_valid(aInValid), .in_ready(aInReady),
    .in_data(aInData), .in_last(aInLast), .out_valid(aOutValid), .out_ready(aOutReady),
    .out_data(aOutData), .out_lane_valid(aLaneValid), .out_last(aOutLast), .busy(aBusy)
  );

  systolic_skew_stream #(.LANES(4), .DATA_W(32), .MODE(1)) dutB (
    .clk(clk), .reset(reset), .flush(bFlush), .in_valid(bInValid), .in_ready(bInReady),
    .in_data(bInData), .in_last(bInLast), .out_valid(bOutValid), .out_ready(bOutReady),
    .out_data(bOutData), .out_lane_valid(bLaneValid), .out_last(bOutLast), .busy(bBusy)
  );

  systolic_skew_stream #(.LANES(1), .DATA_W(32), .MODE(0)) dutC (
    .clk(clk), .reset(reset), .flush(cFlush), .in_valid(cInValid), .in_ready(cInReady),
    .in_data(cInData), .in_last(cInLast), .out_valid(cOutValid), .out_ready(cOutReady),
    .out_data(cOutData), .out_lane_valid(cLaneValid), .out_last(cOutLast), .busy(cBusy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkBeat(input string tag, input logic vObs, input logic [3:0] lvObs,
                           input logic [31:0] dObs [3:0], input logic lastObs,
                           input logic [3:0] lvExp, input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3, input logic lastExp);
    checks++;
    assert (lvObs === lvExp) else begin
      failures++;
      $error("FAIL %s.lane_valid observed=%b expected=%b", tag, lvObs, lvExp);
    end
    checkBit({tag, ".out_valid"}, vObs, |lvExp);
    checkVal({tag, ".d0"}, dObs[0], e0);
    checkVal({tag, ".d1"}, dObs[1], e1);
    checkVal({tag, ".d2"}, dObs[2], e2);
    checkVal({tag, ".d3"}, dObs[3], e3);
    checkBit({tag, ".out_last"}, lastObs, lastExp);
  endtask

  task automatic applyStimulus(input logic valid, input logic last,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic [31:0] d2, input logic [31:0] d3);
    aInValid   = valid;
    aInLast    = last;
    aInData[0] = d0;
    aInData[1] = d1;
    aInData[2] = d2;
    aInData[3] = d3;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] lvExp,
                             input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3, input logic lastExp);
    checkBeat(tag, aOutValid, aLaneValid, aOutData, aOutLast, lvExp, e0, e1, e2, e3, lastExp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    aFlush = 0; aOutReady = 1; applyStimulus(0, 0, 0, 0, 0, 0);
    bFlush = 0; bOutReady = 1; bInValid = 0; bInLast = 0;
    for (int k = 0; k < 4; k++) bInData[k] = '0;
    cFlush = 0; cOutReady = 1; cInValid = 0; cInLast = 0; cInData[0] = '0;
    #2;
    checkOutput("reset_outputs", 4'b0000, 0, 0, 0, 0, 0);
    checkBit("reset_busy", aBusy, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checkBit("reset_in_ready", aInReady, 1'b1);
    tick;

    // single-vector frame, SKEW
    applyStimulus(1, 1, 10, 20, 30, 40);
    #1 checkBit("t1_in_ready_c0", aInReady, 1'b1);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1 checkOutput("t1_c1", 4'b0001, 10, 0, 0, 0, 0);
    checkBit("t1_in_ready_c1", aInReady, 1'b0);
    checkBit("t1_busy_c1", aBusy, 1'b1);
    tick;
    checkOutput("t1_c2", 4'b0010, 0, 20, 0, 0, 0);
    tick;
    checkOutput("t1_c3", 4'b0100, 0, 0, 30, 0, 0);
    checkBit("t1_in_ready_c3", aInReady, 1'b0);
    tick;
    checkOutput("t1_c4", 4'b1000, 0, 0, 0, 40, 1);
    checkBit("t1_in_ready_c4", aInReady, 1'b0);
    tick;
    checkOutput("t1_c5", 4'b0000, 0, 0, 0, 0, 0);
    checkBit("t1_busy_c5", aBusy, 1'b0);
    checkBit("t1_in_ready_c5", aInReady, 1'b1);
    tick;

    // three-vector frame with a four-cycle stall
    applyStimulus(1, 0, 1, 2, 3, 4);
    tick;
    applyStimulus(1, 0, 5, 6, 7, 8);
    #1 checkOutput("t3_c1", 4'b0001, 1, 0, 0, 0, 0);
    tick;
    applyStimulus(1, 1, 9, 10, 11, 12);
    aOutReady = 0;
    for (int c = 2; c <= 5; c++) begin
      #1 checkOutput($sformatf("t3_stall_c%0d", c), 4'b0011, 5, 2, 0, 0, 0);
      checkBit($sformatf("t3_in_ready_c%0d", c), aInReady, 1'b0);
      tick;
    end
    aOutReady = 1;
    #1 checkBit("t3_in_ready_c6", aInReady, 1'b1);
    checkOutput("t3_c6", 4'b0011, 5, 2, 0, 0, 0);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1 checkOutput("t3_c7", 4'b0111, 9, 6, 3, 0, 0);
    tick;
    checkOutput("t3_c8", 4'b1110, 0, 10, 7, 4, 0);
    tick;
    checkOutput("t3_c9", 4'b1100, 0, 0, 11, 8, 0);
    tick;
    checkOutput("t3_c10", 4'b1000, 0, 0, 0, 12, 1);
    tick;
    checkOutput("t3_c11", 4'b0000, 0, 0, 0, 0, 0);
    checkBit("t3_busy_c11", aBusy, 1'b0);
    tick;

    // input gap between two vectors
    applyStimulus(1, 0, 1, 2, 3, 4);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1 checkOutput("t4_c1", 4'b0001, 1, 0, 0, 0, 0);
    tick;
    applyStimulus(1, 1, 5, 6, 7, 8);
    #1 checkOutput("t4_c2", 4'b0010, 0, 2, 0, 0, 0);
    checkBit("t4_in_ready_c2", aInReady, 1'b1);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1 checkOutput("t4_c3", 4'b0101, 5, 0, 3, 0, 0);
    checkBit("t4_in_ready_c3", aInReady, 1'b0);
    tick;
    checkOutput("t4_c4", 4'b1010, 0, 6, 0, 4, 0);
    tick;
    checkOutput("t4_c5", 4'b0100, 0, 0, 7, 0, 0);
    tick;
    checkOutput("t4_c6", 4'b1000, 0, 0, 0, 8, 1);
    tick;
    checkBit("t4_busy_c7", aBusy, 1'b0);
    tick;

    // flush while draining under backpressure
    applyStimulus(1, 1, 1, 2, 3, 4);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 0);
    aOutReady = 0;
    #1 checkOutput("t5_c1", 4'b0001, 1, 0, 0, 0, 0);
    tick;
    checkOutput("t5_hold_c2", 4'b0001, 1, 0, 0, 0, 0);
    checkBit("t5_busy_c2", aBusy, 1'b1);
    aFlush = 1;
    tick;
    aFlush = 0;
    #1 checkOutput("t5_after_flush", 4'b0000, 0, 0, 0, 0, 0);
    checkBit("t5_busy_after_flush", aBusy, 1'b0);
    checkBit("t5_in_ready_after_flush", aInReady, 1'b1);
    aOutReady = 1;
    applyStimulus(1, 1, 21, 22, 23, 24);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1 checkOutput("t5_new_c1", 4'b0001, 21, 0, 0, 0, 0);
    tick;
    checkOutput("t5_new_c2", 4'b0010, 0, 22, 0, 0, 0);
    tick;
    checkOutput("t5_new_c3", 4'b0100, 0, 0, 23, 0, 0);
    tick;
    checkOutput("t5_new_c4", 4'b1000, 0, 0, 0, 24, 1);
    tick;
    checkBit("t5_new_busy_c5", aBusy, 1'b0);
    tick;

    // DESKEW: lane i live at cycle i realigns at cycle 4; last tag follows lane 0
    for (int c = 0; c < 4; c++) begin
      for (int k = 0; k < 4; k++) bInData[k] = (k == c) ? (c + 1) : 0;
      bInValid = 1;
      bInLast  = (c == 3);
      #1 checkBit($sformatf("t2_in_ready_c%0d", c), bInReady, 1'b1);
      if (c > 0)
        checkBeat($sformatf("t2_c%0d", c), bOutValid, bLaneValid, bOutData, bOutLast,
                  4'b1110 << (3 - c), 0, 0, 0, 0, 0);
      tick;
    end
    bInValid = 0;
    bInLast  = 0;
    for (int k = 0; k < 4; k++) bInData[k] = '0;
    #1 checkBeat("t2_c4", bOutValid, bLaneValid, bOutData, bOutLast, 4'b1111, 1, 2, 3, 4, 0);
    tick;
    checkBeat("t2_c5", bOutValid, bLaneValid, bOutData, bOutLast, 4'b0111, 0, 0, 0, 0, 0);
    tick;
    checkBeat("t2_c6", bOutValid, bLaneValid, bOutData, bOutLast, 4'b0011, 0, 0, 0, 0, 0);
    tick;
    checkBeat("t2_c7", bOutValid, bLaneValid, bOutData, bOutLast, 4'b0001, 0, 0, 0, 0, 1);
    checkBit("t2_busy_c7", bBusy, 1'b1);
    tick;
    checkBit("t2_busy_c8", bBusy, 1'b0);
    checkBit("t2_out_valid_c8", bOutValid, 1'b0);

    // LANES = 1
    cInValid   = 1;
    cInLast    = 1;
    cInData[0] = 32'd99;
    tick;
    cInValid   = 0;
    cInLast    = 0;
    cInData[0] = '0;
    #1 checkVal("l1_data_c1", cOutData[0], 32'd99);
    checkBit("l1_valid_c1", cOutValid, 1'b1);
    checkBit("l1_lane_valid_c1", cLaneValid[0], 1'b1);
    checkBit("l1_last_c1", cOutLast, 1'b1);
    checkBit("l1_busy_c1", cBusy, 1'b1);
    checkBit("l1_in_ready_c1", cInReady, 1'b0);
    tick;
    checkBit("l1_busy_c2", cBusy, 1'b0);
    checkBit("l1_valid_c2", cOutValid, 1'b0);

    // asynchronous reset pulse in the middle of a frame
    applyStimulus(1, 0, 1, 2, 3, 4);
    tick;
    applyStimulus(1, 0, 5, 6, 7, 8);
    #1 checkBit("t6_busy_c1", aBusy, 1'b1);
    tick;
    applyStimulus(0, 0, 0, 0, 0, 0);
    #1 checkOutput("t6_c2", 4'b0011, 5, 2, 0, 0, 0);
    #1 reset = 1'b1;
    #1 checkOutput("t6_async_reset", 4'b0000, 0, 0, 0, 0, 0);
    checkBit("t6_busy_in_reset", aBusy, 1'b0);
    #1 reset = 1'b0;
    tick;
    for (int c = 0; c < 6; c++) begin
      checkBit($sformatf("t6_no_last_%0d", c), aOutLast, 1'b0);
      checkBit($sformatf("t6_no_valid_%0d", c), aOutValid, 1'b0);
      tick;
    end
    checkBit("t6_in_ready_end", aInReady, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
